// File: rtl/jpeg_mcu_pingpong_ctrl_pkg.sv
// Shared constants for the JPEG MCU ping-pong bank scheduler:
// read-state encodings and MCU geometry (dim / last block index).
package jpeg_mcu_pingpong_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OUT  = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;

    localparam logic [4:0] DIM_411  = 5'd16;
    localparam logic [4:0] DIM_444  = 5'd8;
    localparam logic [3:0] LAST_411 = 4'd5;
    localparam logic [3:0] LAST_444 = 4'd2;

    function automatic logic [4:0] mcu_dim(input logic is_411);
        return is_411 ? DIM_411 : DIM_444;
    endfunction

    function automatic logic [3:0] last_blk(input logic is_411);
        return is_411 ? LAST_411 : LAST_444;
    endfunction

endpackage

// File: rtl/jpeg_mcu_raster_cnt.sv
// Raster row/col walker for one MCU bank with pixel coordinate math.
// JPEG_EDGE_CROP_EN limits the walk to the part of the MCU inside the image.
module jpeg_mcu_raster_cnt
    import jpeg_mcu_pingpong_ctrl_pkg::*;
#(
    parameter int XW = 13,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          step,
    input  logic          is_411,
    input  logic [PW-1:0] width,
    input  logic [PW-1:0] height,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] y0,
    output logic [7:0]    addr,
    output logic [PW-1:0] pix_x,
    output logic [PW-1:0] pix_y,
    output logic          start_final,
    output logic          step_final
);

    logic [3:0]    row;
    logic [3:0]    col;
    logic [4:0]    vc;
    logic [4:0]    vr;
    logic [4:0]    vc_n;
    logic [4:0]    vr_n;
    logic [4:0]    dim;
    logic [PW-1:0] bx;
    logic [PW-1:0] by;
    logic          wrap;
    logic [4:0]    nrow;
    logic [4:0]    ncol;

    assign dim = mcu_dim(is_411);
    assign bx  = is_411 ? PW'({x0, 4'b0}) : PW'({x0, 3'b0});
    assign by  = is_411 ? PW'({y0, 4'b0}) : PW'({y0, 3'b0});

`ifdef JPEG_EDGE_CROP_EN
    // An MCU starting at or past the image edge still yields one pixel.
    function automatic logic [4:0] lim(
        input logic [PW-1:0] base,
        input logic [PW-1:0] size,
        input logic [4:0]    d
    );
        logic [PW-1:0] rem;
        rem = size - base;
        if (base >= size) return 5'd1;
        if (rem < PW'(d)) return rem[4:0];
        return d;
    endfunction

    assign vc_n = lim(bx, width, dim);
    assign vr_n = lim(by, height, dim);
`else
    logic unused;
    assign unused = ^{width, height};
    assign vc_n   = dim;
    assign vr_n   = dim;
`endif

    assign wrap        = ({1'b0, col} == vc - 5'd1);
    assign nrow        = {1'b0, row} + {4'd0, wrap};
    assign ncol        = wrap ? 5'd0 : {1'b0, col} + 5'd1;
    assign step_final  = (nrow == vr - 5'd1) && (ncol == vc - 5'd1);
    assign start_final = (vc_n == 5'd1) && (vr_n == 5'd1);

    always_ff @(posedge clk) begin
        if (clr) begin
            row <= '0;
            col <= '0;
            vc  <= '0;
            vr  <= '0;
        end else if (start) begin
            row <= '0;
            col <= '0;
            vc  <= vc_n;
            vr  <= vr_n;
        end else if (step) begin
            row <= nrow[3:0];
            col <= ncol[3:0];
        end
    end

    assign addr  = is_411 ? {row, col} : {1'b0, row, col[2:0]};
    assign pix_x = bx + PW'(col);
    assign pix_y = by + PW'(row);

endmodule

// File: rtl/jpeg_mcu_pingpong_ctrl.sv
// Two-bank MCU buffer scheduler: fill tracking, read FSM and handshakes.
// Optional edge cropping is enabled with JPEG_EDGE_CROP_EN.
module jpeg_mcu_pingpong_ctrl
    import jpeg_mcu_pingpong_ctrl_pkg::*;
#(
    parameter int XW = 13,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pic_end,
    input  logic          pic_is_411,
    input  logic [PW-1:0] width,
    input  logic [PW-1:0] height,
    input  logic          wr_blk_done,
    input  logic [3:0]    wr_blk_idx,
    input  logic [XW-1:0] wr_x_mcu,
    input  logic [XW-1:0] wr_y_mcu,
    output logic          wr_bank,
    output logic          wr_ready,
    output logic          full_0,
    output logic          full_1,
    output logic          fifo_full,
    input  logic          rd,
    output logic          out_valid,
    output logic          rd_bank,
    output logic [7:0]    rd_addr,
    output logic [PW-1:0] pix_x,
    output logic [PW-1:0] pix_y,
    output logic          last_one,
    output logic          out_end,
    output logic          ovf_err
);

    logic                   clr;
    logic [1:0]             state;
    logic [1:0]             full;
    logic [1:0]             full_n;
    logic [1:0][XW-1:0]     x_mcu;
    logic [1:0][XW-1:0]     y_mcu;
    logic                   wr_fire;
    logic                   rd_free;
    logic                   start;
    logic                   step;
    logic                   start_final;
    logic                   step_final;
    logic                   wr_bank_n;

    assign clr       = rst | pic_end;
    assign wr_fire   = wr_blk_done & wr_ready
                     & (wr_blk_idx == last_blk(pic_is_411));
    assign rd_free   = (state == ST_LAST) & rd;
    assign start     = (state == ST_IDLE) & full[rd_bank];
    assign step      = (state == ST_OUT) & rd;
    assign wr_bank_n = wr_bank ^ wr_fire;

    // Fill and free never hit the same bank: wr_ready masks a full bank.
    always_comb begin
        full_n = full;
        if (wr_fire) full_n[wr_bank] = 1'b1;
        if (rd_free) full_n[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            full     <= '0;
            x_mcu    <= '0;
            y_mcu    <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_ready <= 1'b0;
            ovf_err  <= 1'b0;
            out_end  <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            full     <= full_n;
            wr_bank  <= wr_bank_n;
            wr_ready <= ~full_n[wr_bank_n];
            ovf_err  <= ovf_err | (wr_blk_done & ~wr_ready);
            out_end  <= rd_free;
            if (wr_fire) begin
                x_mcu[wr_bank] <= wr_x_mcu;
                y_mcu[wr_bank] <= wr_y_mcu;
            end
            if (rd_free) rd_bank <= ~rd_bank;
            unique case (state)
                ST_IDLE: if (start) state <= start_final ? ST_LAST : ST_OUT;
                ST_OUT:  if (step && step_final) state <= ST_LAST;
                ST_LAST: if (rd) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign full_0    = full[0];
    assign full_1    = full[1];
    assign fifo_full = start;
    assign out_valid = (state == ST_OUT) || (state == ST_LAST);
    assign last_one  = (state == ST_LAST);

    jpeg_mcu_raster_cnt #(
        .XW(XW),
        .PW(PW)
    ) u_cnt (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .step       (step),
        .is_411     (pic_is_411),
        .width      (width),
        .height     (height),
        .x0         (x_mcu[rd_bank]),
        .y0         (y_mcu[rd_bank]),
        .addr       (rd_addr),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .start_final(start_final),
        .step_final (step_final)
    );

endmodule

// File: tb/tb_jpeg_mcu_pingpong_ctrl.sv
// Bench for jpeg_mcu_pingpong_ctrl: vector table, directed corner cases,
// and a randomized run against a pixel-list reference model.
module tb_jpeg_mcu_pingpong_ctrl;

    localparam int XW = 13;
    localparam int PW = 16;
`ifdef JPEG_EDGE_CROP_EN
    localparam bit CROP = 1'b1;
`else
    localparam bit CROP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          pic_end;
    logic          pic_is_411;
    logic [PW-1:0] width;
    logic [PW-1:0] height;
    logic          wr_blk_done;
    logic [3:0]    wr_blk_idx;
    logic [XW-1:0] wr_x_mcu;
    logic [XW-1:0] wr_y_mcu;
    logic          wr_bank;
    logic          wr_ready;
    logic          full_0;
    logic          full_1;
    logic          fifo_full;
    logic          rd;
    logic          out_valid;
    logic          rd_bank;
    logic [7:0]    rd_addr;
    logic [PW-1:0] pix_x;
    logic [PW-1:0] pix_y;
    logic          last_one;
    logic          out_end;
    logic          ovf_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jpeg_mcu_pingpong_ctrl #(.XW(XW), .PW(PW)) dut (
        .clk(clk), .rst(rst), .pic_end(pic_end), .pic_is_411(pic_is_411),
        .width(width), .height(height), .wr_blk_done(wr_blk_done),
        .wr_blk_idx(wr_blk_idx), .wr_x_mcu(wr_x_mcu), .wr_y_mcu(wr_y_mcu),
        .wr_bank(wr_bank), .wr_ready(wr_ready), .full_0(full_0),
        .full_1(full_1), .fifo_full(fifo_full), .rd(rd),
        .out_valid(out_valid), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .pix_x(pix_x), .pix_y(pix_y), .last_one(last_one),
        .out_end(out_end), .ovf_err(ovf_err)
    );

    typedef struct {
        logic       done;
        logic [3:0] idx;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int vlim(input int rem, input int dim);
        if (CROP && rem < dim) return rem;
        return dim;
    endfunction

    function automatic logic [63:0] exp_pix(input int x, input int y,
        input int p, input int dim, input int vc, input int vr);
        int r;
        int c;
        logic [7:0]  a;
        logic [15:0] px;
        logic [15:0] py;
        logic        l;
        r  = p / vc;
        c  = p % vc;
        a  = 8'(r * dim + c);
        px = 16'(x * dim + c);
        py = 16'(y * dim + r);
        l  = (p == vc * vr - 1);
        return {23'd0, a, px, py, l};
    endfunction

    function automatic logic [63:0] act_pix();
        return {23'd0, rd_addr, pix_x, pix_y, last_one};
    endfunction

    task automatic do_reset();
        rst = 1'b1; pic_end = 1'b0; rd = 1'b0;
        wr_blk_done = 1'b0; wr_blk_idx = '0;
        wr_x_mcu = '0; wr_y_mcu = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic write_mcu(input int x, input int y, input int nblk);
        for (int b = 0; b < nblk; b++) begin
            wr_blk_done = 1'b1;
            wr_blk_idx  = 4'(b);
            wr_x_mcu    = XW'(x);
            wr_y_mcu    = XW'(y);
            step();
        end
        wr_blk_done = 1'b0;
    endtask

    // Drain one MCU with rd held high; optionally complete another MCU's
    // final block on the very cycle of the last read.
    task automatic drain(input string tag, input int x, input int y,
                         input bit fill, input int fx, input int fy,
                         output int n);
        int dim;
        int vc;
        int vr;
        int guard;
        dim = pic_is_411 ? 16 : 8;
        vc  = vlim(int'(width) - x * dim, dim);
        vr  = vlim(int'(height) - y * dim, dim);
        guard = 0;
        while (!out_valid && guard < 10) begin
            step();
            guard++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        n  = 0;
        rd = 1'b1;
        while (out_valid && n < 300) begin
            chk({tag, "_pix"}, act_pix(), exp_pix(x, y, n, dim, vc, vr));
            if (fill && n == vc * vr - 1) begin
                wr_blk_done = 1'b1;
                wr_blk_idx  = pic_is_411 ? 4'd5 : 4'd2;
                wr_x_mcu    = XW'(fx);
                wr_y_mcu    = XW'(fy);
            end
            n++;
            step();
            wr_blk_done = 1'b0;
        end
        rd = 1'b0;
        chk({tag, "_count"}, 64'(n), 64'(vc * vr));
        chk({tag, "_out_end"}, 64'(out_end), 64'd1);
    endtask

    task automatic rand_run(input logic m411, input int cycles);
        int dim;
        int lb;
        int cnt;
        int rdb;
        int wrb;
        int p;
        int nb;
        int wx;
        int wy;
        int n;
        int vc;
        int vr;
        bit act;
        bit pend_end;
        bit st;
        bit fin;
        bit commit;
        logic [1:0] f;
        int qx[$];
        int qy[$];
        pic_is_411 = m411;
        dim    = m411 ? 16 : 8;
        lb     = m411 ? 5 : 2;
        width  = PW'($urandom_range(9, 70));
        height = PW'($urandom_range(9, 70));
        do_reset();
        step();
        act = 0; pend_end = 0; cnt = 0; rdb = 0; wrb = 0; p = 0; nb = 0;
        wx = $urandom_range(0, (int'(width) - 1) / dim);
        wy = $urandom_range(0, (int'(height) - 1) / dim);
        for (int c = 0; c < cycles; c++) begin
            n = 1; vc = 1; vr = 1;
            if (cnt > 0) begin
                vc = vlim(int'(width) - qx[0] * dim, dim);
                vr = vlim(int'(height) - qy[0] * dim, dim);
                n  = vc * vr;
            end
            f = 2'b00;
            if (cnt >= 1) f[rdb] = 1'b1;
            if (cnt == 2) f[rdb ^ 1] = 1'b1;
            chk("rand_ctl",
                {54'd0, out_valid, fifo_full, wr_ready, wr_bank, rd_bank,
                 full_1, full_0, out_end, ovf_err, last_one},
                {54'd0, act, !act && cnt > 0, cnt < 2, 1'(wrb), 1'(rdb),
                 f[1], f[0], pend_end, 1'b0, act && p == n - 1});
            if (act)
                chk("rand_pix", act_pix(),
                    exp_pix(qx[0], qy[0], p, dim, vc, vr));
            rd          = ($urandom_range(0, 3) != 0);
            wr_blk_done = (cnt < 2) && ($urandom_range(0, 1) == 1);
            wr_blk_idx  = 4'(nb);
            wr_x_mcu    = XW'(wx);
            wr_y_mcu    = XW'(wy);
            st     = !act && cnt > 0;
            fin    = act && rd && p == n - 1;
            commit = wr_blk_done && nb == lb;
            if (st) begin
                act = 1; p = 0;
            end else if (act && rd) begin
                if (fin) begin
                    act = 0;
                    void'(qx.pop_front());
                    void'(qy.pop_front());
                    rdb ^= 1;
                end else begin
                    p++;
                end
            end
            if (wr_blk_done) begin
                if (commit) begin
                    qx.push_back(wx);
                    qy.push_back(wy);
                    wrb ^= 1;
                    nb = 0;
                    wx = $urandom_range(0, (int'(width) - 1) / dim);
                    wy = $urandom_range(0, (int'(height) - 1) / dim);
                end else begin
                    nb++;
                end
            end
            cnt = cnt + int'(commit) - int'(fin);
            pend_end = fin;
            step();
        end
        rd = 1'b0;
        wr_blk_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0]  = '{1'b0, 4'd0, 7'b0010000};
        tbl[1]  = '{1'b1, 4'd0, 7'b0010000};
        tbl[2]  = '{1'b1, 4'd1, 7'b0010000};
        tbl[3]  = '{1'b1, 4'd2, 7'b0010000};
        tbl[4]  = '{1'b1, 4'd3, 7'b0010000};
        tbl[5]  = '{1'b1, 4'd4, 7'b0010000};
        tbl[6]  = '{1'b1, 4'd5, 7'b0111010};
        tbl[7]  = '{1'b1, 4'd0, 7'b0111001};
        tbl[8]  = '{1'b1, 4'd1, 7'b0111001};
        tbl[9]  = '{1'b1, 4'd2, 7'b0111001};
        tbl[10] = '{1'b1, 4'd3, 7'b0111001};
        tbl[11] = '{1'b1, 4'd4, 7'b0111001};
        tbl[12] = '{1'b1, 4'd5, 7'b1100001};
        tbl[13] = '{1'b1, 4'd0, 7'b1100101};
        tbl[14] = '{1'b0, 4'd0, 7'b1100101};

        pic_is_411 = 1'b0;
        width  = 16'd64;
        height = 16'd64;
        do_reset();
        chk("reset_state",
            {54'd0, out_valid, fifo_full, full_1, full_0, wr_ready,
             wr_bank, rd_bank, last_one, out_end, ovf_err}, 64'd0);
        step();

        // 444 single MCU
        write_mcu(0, 0, 3);
        chk("444_filled", {61'd0, full_0, fifo_full, out_valid}, 64'b110);
        drain("444", 0, 0, 0, 0, 0, n);
        chk("444_freed", {62'd0, full_0, rd_bank}, 64'b01);
        step();
        chk("444_out_end_pulse", 64'(out_end), 64'd0);

        // 411 ping-pong vector table
        do_reset();
        step();
        pic_is_411 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wr_blk_done = tbl[i].done;
            wr_blk_idx  = tbl[i].idx;
            wr_x_mcu    = XW'(i);
            wr_y_mcu    = XW'(i);
            step();
            chk($sformatf("tbl%0d", i),
                {57'd0, full_1, full_0, wr_ready, wr_bank, ovf_err,
                 fifo_full, out_valid}, {57'd0, tbl[i].exp});
        end
        wr_blk_done = 1'b0;

        // pic_end clears like reset
        pic_end = 1'b1;
        step();
        pic_end = 1'b0;
        chk("pic_end_clear",
            {59'd0, full_1, full_0, ovf_err, out_valid, wr_bank}, 64'd0);
        step();

        // concurrent fill of bank 1 and free of bank 0
        write_mcu(0, 0, 6);
        write_mcu(1, 2, 5);
        drain("conc_a", 0, 0, 1, 1, 2, n);
        chk("conc_flags",
            {60'd0, full_1, full_0, rd_bank, wr_bank}, 64'b1010);
        chk("conc_ready", 64'(wr_ready), 64'd1);
        drain("conc_b", 1, 2, 0, 0, 0, n);

        // edge MCU, width 20
        do_reset();
        step();
        width  = 16'd20;
        height = 16'd16;
        write_mcu(1, 0, 6);
        drain("crop", 1, 0, 0, 0, 0, n);
        chk("crop_total", 64'(n), CROP ? 64'd64 : 64'd256);

        // reset in the middle of a read
        do_reset();
        step();
        pic_is_411 = 1'b0;
        width  = 16'd64;
        height = 16'd64;
        write_mcu(2, 1, 3);
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        rd = 1'b1;
        for (int i = 0; i < 30; i++) step();
        rd  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst",
            {59'd0, out_valid, full_1, full_0, rd_bank, wr_bank}, 64'd0);
        step();
        write_mcu(3, 0, 3);
        drain("after_rst", 3, 0, 0, 0, 0, n);

        rand_run(1'b0, 900);
        rand_run(1'b1, 1600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
